load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle memory access stage between the register file and data memory.
- Consumes the register file's two read values: base address and store data.
- Runs a req/gnt/rvalid handshake with data memory.
- For loads, drives the register file write port (wen/write_addr/write_data) for exactly one cycle.
- Asserts busy so the fetch/decode logic stalls the core while an access is in flight.

Parameters:
- addr_w, 4, register file address width (2**addr_w registers).
- TIMEOUT, 16, maximum number of WAIT cycles before a load is aborted; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ld_start  input  1  one-cycle load request; sampled only in IDLE.
- st_start  input  1  one-cycle store request; sampled only in IDLE.
- base  input  8  base address (register file read0 value).
- offset  input  8  two's-complement address offset.
- st_data  input  8  store data (register file read1 value).
- dest  input  addr_w  load destination register.
- mem_req  output  1  memory request; held high until granted.
- mem_we  output  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  output  8  latched effective address.
- mem_wdata  output  8  latched store data.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  load data valid this cycle.
- mem_rdata  input  8  load data.
- rf_wen  output  1  register file write enable.
- rf_waddr  output  addr_w  register file write address.
- rf_wdata  output  8  register file write data.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on an illegal request or a timeout.

Behaviour:
- Reset: state=IDLE; every output 0; latched addr/data/dest/timeout counter 0. Reset mid-operation abandons the access with no register file write.
- Every output is a function of flops only: no combinational path from any input to any output.
- IDLE:
  - ld_start only: latch addr=(base+offset) mod 256, latch dest, go to REQ with op=LD.
  - st_start only: latch addr and st_data, go to REQ with op=ST.
  - Both high together: err pulse next cycle; stay IDLE; no latching.
- REQ:
  - mem_req=1; mem_we=(op==ST); mem_addr and mem_wdata hold their latched values.
  - mem_gnt=0: stay in REQ indefinitely (no timeout here).
  - mem_gnt=1 and ST: go to IDLE, done pulse next cycle.
  - mem_gnt=1 and LD: go to WAIT, clear the timeout counter.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1: capture mem_rdata, go to WB.
  - Otherwise the counter increments. On the cycle the counter reaches TIMEOUT (counter==TIMEOUT-1 with rvalid low): go to IDLE, err pulse, no writeback.
  - mem_rvalid in the same cycle as mem_gnt (while in REQ) is ignored.
- WB:
  - rf_wen=1, rf_waddr=dest, rf_wdata=captured data for exactly one cycle.
  - Go to IDLE; done asserts in the same cycle as rf_wen.
- Register 0 gets no special treatment.
- ld_start/st_start while busy are ignored silently. The upstream stage must stall on busy.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the first WAIT cycle:
  - Load: start at cycle 0 gives rf_wen at cycle 3.
  - Store: start at cycle 0 gives done at cycle 2.
- busy is high from the cycle after the start is accepted through the WB cycle inclusive.

Decomposition:
- Package roe_lsu_pkg holds:
  - lsu_state_t enum (IDLE, REQ, WAIT, WB).
  - lsu_op_t enum (LD, ST).
  - localparam DATA_W=8.
- One sub-module: lsu_timeout_ctr.
  - Inputs: clear, enable.
  - Output: expired.
  - Contains the 8-bit counter compared against TIMEOUT.
- FSM and datapath latches live in load_store_unit.

Test Plan:
- Load, zero wait: base=0x10, offset=0x05, dest=3, gnt in the first REQ cycle, rvalid with rdata=0xA5 in the first WAIT cycle -> mem_addr=0x15, mem_we=0, rf_wen=1/rf_waddr=3/rf_wdata=0xA5 at cycle 3, done the same cycle, busy cycles 1-3.
- Store with wrap and gnt delay: base=0xFE, offset=0x04, st_data=0x3C, gnt held off 2 cycles -> mem_addr=0x02, mem_we=1, mem_wdata=0x3C, mem_req high 3 cycles, done one cycle after gnt, rf_wen never asserted.
- Timeout: TIMEOUT=4, load granted, rvalid never asserted -> err pulse exactly 4 cycles after entering WAIT, return to IDLE, rf_wen stays 0; a following load then completes normally.
- Simultaneous ld_start and st_start in IDLE -> err pulse, mem_req stays 0, busy stays 0.
- Start while busy: assert ld_start during WAIT with different dest/base -> ignored; the original dest is written.
- Reset mid-WAIT: drop rst_n while in WAIT -> all outputs 0 immediately (asynchronous); a late mem_rvalid after release causes no rf_wen.

Source files
------------

// File: rtl/roe_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : roe_lsu_pkg
//  Description : Shared types and constants for the load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
package roe_lsu_pkg;

    // Width of the data path and of memory addresses.
    localparam int DATA_W = 8;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_t;

    // Kind of access being carried out.
    typedef enum logic {
        LD = 1'b0,
        ST = 1'b1
    } lsu_op_t;

endpackage
`default_nettype wire

// File: rtl/lsu_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_timeout_ctr
//  Description : Counts cycles spent waiting for load data; flags the last
//                allowed cycle so the sequencer can abort the load.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Last wait cycle index; abort happens when the counter sits here and
    // data still has not arrived.
    localparam logic [7:0] c_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Wait-cycle counter: clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (clear) begin
            r_cnt <= 8'd0;
        end else if (enable) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expired = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Multi-cycle memory access stage. Latches address/data,
//                runs the req/gnt/rvalid handshake with data memory and
//                writes load results back to the register file.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import roe_lsu_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              st_start,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] st_data,
    input  logic [ADDR_W-1:0] dest,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;
    lsu_op_t           r_op;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_dest;
    logic              r_done;
    logic              r_err;

    logic              w_latch_ld;
    logic              w_latch_st;
    logic              w_capture;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_expired;

    lsu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_cnt_clr),
        .enable  (w_cnt_en),
        .expired (w_expired)
    );

    // State register plus the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_latch_ld  = 1'b0;
        w_latch_st  = 1'b0;
        w_capture   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (ld_start && st_start) begin
                    // Ambiguous request: reject without latching anything.
                    w_err_nxt = 1'b1;
                end else if (ld_start) begin
                    w_latch_ld  = 1'b1;
                    w_state_nxt = REQ;
                end else if (st_start) begin
                    w_latch_st  = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // rvalid is ignored here, even in the grant cycle.
                if (mem_gnt) begin
                    if (r_op == ST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = WB;
                end else if (w_expired) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_en    = 1'b1;
                end
            end
            WB: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latches and load-data capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= LD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_dest  <= '0;
        end else begin
            if (w_latch_ld) begin
                r_op   <= LD;
                r_addr <= base + offset;
                r_dest <= dest;
            end
            if (w_latch_st) begin
                r_op    <= ST;
                r_addr  <= base + offset;
                r_wdata <= st_data;
            end
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // All outputs are decoded from flops only.
    assign mem_req   = (r_state == REQ);
    assign mem_we    = (r_state == REQ) && (r_op == ST);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rf_wen    = (r_state == WB);
    assign rf_waddr  = r_dest;
    assign rf_wdata  = r_rdata;
    assign busy      = (r_state != IDLE);
    assign done      = r_done || (r_state == WB);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit: directed vector
//                table, randomized accesses against a timeline model, and
//                hand-written reset / illegal-request sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_ADDR_W  = 4;
    localparam int c_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_start = 1'b0;
    logic       st_start = 1'b0;
    logic [7:0] base = 8'h00;
    logic [7:0] offset = 8'h00;
    logic [7:0] st_data = 8'h00;
    logic [3:0] dest = 4'h0;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_gnt = 1'b0;
    logic       mem_rvalid = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       rf_wen;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit #(
        .ADDR_W  (c_ADDR_W),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .st_start   (st_start),
        .base       (base),
        .offset     (offset),
        .st_data    (st_data),
        .dest       (dest),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Access description plus the outcome expected from it.
    typedef struct {
        bit         is_st;
        logic [7:0] base;
        logic [7:0] offset;
        logic [7:0] sdata;
        logic [3:0] dest;
        int         g;        // cycles gnt is held off
        int         r;        // WAIT cycles before rvalid, -1 = never
        logic [7:0] rdata;
        bit         inj;      // inject ignored noise while busy
        logic [7:0] exp_addr;
        bit         exp_ok;   // 1 = done, 0 = timeout error
    } vec_t;

    logic [33:0] act;
    assign act = {mem_req, mem_we, mem_addr, mem_wdata, rf_wen, rf_waddr,
                  rf_wdata, busy, done, err};

    function automatic logic [33:0] pk(input logic req, input logic we,
                                       input logic [7:0] addr, input logic [7:0] wd,
                                       input logic wen, input logic [3:0] wa,
                                       input logic [7:0] rd, input logic bsy,
                                       input logic dn, input logic er);
        return {req, we, addr, wd, wen, wa, rd, bsy, dn, er};
    endfunction

    task automatic check(input string name, input logic [33:0] exp, input logic [33:0] care);
        n_cmp++;
        if ((act & care) !== (exp & care)) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (care %h)", name, act, exp, care);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        ld_start   = 1'b0;
        st_start   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // Runs one access cycle by cycle. Expected outputs come from the access
    // timeline: start at cycle 0, request cycles 1..1+g, wait cycles from 2+g.
    task automatic run_vec(input vec_t v, input string tag);
        int   g;
        int   last;
        int   bend;
        int   k_rv;
        bit   ld_ok;
        bit   req;
        logic [33:0] exp;
        logic [33:0] care;
        g     = v.g;
        ld_ok = !v.is_st && v.exp_ok;
        k_rv  = (!v.is_st && v.r >= 0) ? 2 + g + v.r : -10;
        if (v.is_st) begin
            bend = 1 + g;
            last = 2 + g;
        end else if (ld_ok) begin
            bend = 3 + g + v.r;
            last = bend;
        end else begin
            bend = 1 + g + c_TIMEOUT;
            last = bend + 1;
        end
        for (int k = 0; k <= last + 1; k++) begin
            req  = (k >= 1) && (k <= 1 + g);
            exp  = pk(req, req && v.is_st, v.exp_addr, v.sdata,
                      ld_ok && (k == last), v.dest, v.rdata,
                      (k >= 1) && (k <= bend),
                      v.exp_ok && (k == last), !v.exp_ok && (k == last));
            care = pk(1'b1, 1'b1, {8{req}}, {8{req && v.is_st}}, 1'b1,
                      {4{ld_ok && (k == last)}}, {8{ld_ok && (k == last)}},
                      1'b1, 1'b1, 1'b1);
            check($sformatf("%s cyc%0d", tag, k), exp, care);
            ld_start = 1'b0;
            st_start = 1'b0;
            base     = 8'($urandom);
            offset   = 8'($urandom);
            st_data  = 8'($urandom);
            dest     = 4'($urandom);
            if (k == 0) begin
                ld_start = !v.is_st;
                st_start = v.is_st;
                base     = v.base;
                offset   = v.offset;
                st_data  = v.sdata;
                dest     = v.dest;
            end else if (v.inj && k <= bend) begin
                if (!v.is_st && k == 2 + g) begin
                    ld_start = 1'b1;
                    dest     = v.dest ^ 4'hF;
                end else begin
                    ld_start = 1'($urandom_range(0, 1));
                    st_start = 1'($urandom_range(0, 1));
                end
            end
            mem_gnt    = (k == 1 + g) ||
                         (v.inj && !v.is_st && k >= 2 + g && k <= bend &&
                          $urandom_range(0, 1) == 1);
            mem_rvalid = (k == k_rv) || (v.inj && req && $urandom_range(0, 1) == 1);
            mem_rdata  = (k == k_rv) ? v.rdata : 8'($urandom);
            tick();
        end
        quiet_inputs();
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, 8'h10, 8'h05, 8'h00, 4'd3,  0,  0, 8'hA5, 1'b0, 8'h15, 1'b1};
        tbl[1] = '{1'b1, 8'hFE, 8'h04, 8'h3C, 4'd0,  2,  0, 8'h00, 1'b0, 8'h02, 1'b1};
        tbl[2] = '{1'b0, 8'h20, 8'h10, 8'h00, 4'd7,  0, -1, 8'h00, 1'b0, 8'h30, 1'b0};
        tbl[3] = '{1'b0, 8'h80, 8'h7F, 8'h00, 4'd9,  1,  1, 8'h5A, 1'b0, 8'hFF, 1'b1};
        tbl[4] = '{1'b0, 8'h05, 8'hFB, 8'h00, 4'd0,  0,  3, 8'hC3, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{1'b0, 8'h40, 8'h02, 8'h00, 4'd5,  0,  2, 8'h77, 1'b1, 8'h42, 1'b1};
        tbl[6] = '{1'b1, 8'h7F, 8'h81, 8'h99, 4'd0,  0,  0, 8'h00, 1'b1, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 4'd15, 3,  4, 8'h6E, 1'b0, 8'hFE, 1'b0};

        // Reset state: every output low.
        tick();
        tick();
        check("reset", 34'd0, {34{1'b1}});
        rst_n = 1'b1;
        tick();
        check("post-reset idle", 34'd0, {34{1'b1}});

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            rv.is_st    = 1'($urandom_range(0, 1));
            rv.base     = 8'($urandom);
            rv.offset   = 8'($urandom);
            rv.sdata    = 8'($urandom);
            rv.dest     = 4'($urandom);
            rv.g        = int'($urandom_range(0, 3));
            rv.r        = int'($urandom_range(0, c_TIMEOUT + 1));
            if (rv.r == c_TIMEOUT + 1) rv.r = -1;
            rv.rdata    = 8'($urandom);
            rv.inj      = 1'($urandom_range(0, 1));
            rv.exp_addr = 8'((int'(rv.base) + int'(rv.offset)) % 256);
            rv.exp_ok   = rv.is_st || (rv.r >= 0 && rv.r < c_TIMEOUT);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Simultaneous load and store request: error pulse, stays idle.
        ld_start = 1'b1;
        st_start = 1'b1;
        base     = 8'h11;
        offset   = 8'h22;
        tick();
        quiet_inputs();
        check("both-start err", pk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1),
              pk(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1));
        tick();
        check("both-start after", 34'd0,
              pk(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1));

        // Reset while waiting for load data, then a stale rvalid.
        ld_start = 1'b1;
        base     = 8'h33;
        offset   = 8'h01;
        dest     = 4'd6;
        tick();
        ld_start = 1'b0;
        mem_gnt  = 1'b1;
        tick();
        mem_gnt  = 1'b0;
        check("mid-wait busy", pk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0),
              pk(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1));
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset", 34'd0, {34{1'b1}});
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stale rvalid %0d", k), 34'd0, {34{1'b1}});
        end
        quiet_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
